// File: rtl/cop_irq_timer_if.sv
// Signal bundle between the coprocessor-0 timer/interrupt front end and the
// pipeline control stage (mtc0 writes, STATUS gating, irq request/ack).
interface cop_irq_if;
    logic [4:0]  hw_irq;
    logic [1:0]  sw_ip;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic        status_erl;
    logic        count_wr;
    logic        compare_wr;
    logic [31:0] wr_data;
    logic [31:0] count_out;
    logic [31:0] compare_out;
    logic [7:0]  ip_out;
    logic        irq_req;
    logic [2:0]  irq_line;
    logic        irq_ack;

    modport master (
        output hw_irq, sw_ip, status_im, status_ie, status_exl, status_erl,
               count_wr, compare_wr, wr_data, irq_ack,
        input  count_out, compare_out, ip_out, irq_req, irq_line
    );

    modport slave (
        input  hw_irq, sw_ip, status_im, status_ie, status_exl, status_erl,
               count_wr, compare_wr, wr_data, irq_ack,
        output count_out, compare_out, ip_out, irq_req, irq_line
    );
endinterface

// File: rtl/cop_irq_timer.sv
// COP0 COUNT/COMPARE timer, external irq synchroniser and STATUS-gated
// request/ack interrupt front end for the pipeline control stage.
//
// state    | meaning
// IDLE     | no request outstanding; watching pend & enable
// REQ      | irq_req high, irq_line frozen, waiting for ack or withdraw
// WAIT_EXL | ack taken; hold off until EXL/ERL shows handler entry
module cop_irq_timer #(
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic     clk,
    input logic     rst,
    cop_irq_if.slave bus
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_EXL = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [31:0]                 count_q, count_d;
    logic [31:0]                 compare_q, compare_d;
    logic                        ti_q, ti_d;
    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic [7:0]                  ip_q, ip_d;
    logic                        irq_req_q, irq_req_d;
    logic [2:0]                  irq_line_q, irq_line_d;

    logic        presc_wrap;
    logic [31:0] count_inc;
    logic [7:0]  pend;
    logic        enable;
    logic        take;
    logic [2:0]  pend_idx;

    always_comb begin
        presc_wrap = (presc_q == PW'(COUNT_DIV - 1));
        count_inc  = count_q + 32'd1;
        presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
        count_d    = count_q;
        compare_d  = compare_q;
        ti_d       = ti_q;
        // A software load replaces the tick entirely, so it can never match.
        if (bus.count_wr) begin
            count_d = bus.wr_data;
            presc_d = '0;
        end else if (presc_wrap) begin
            count_d = count_inc;
            if (count_inc == compare_q) begin
                ti_d = 1'b1;
            end
        end
        if (bus.compare_wr) begin
            compare_d = bus.wr_data;
            ti_d      = 1'b0;
        end
    end

    always_comb begin
        sync_d[0] = bus.hw_irq;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        // ti_d is used so the timer bit appears on the same edge COUNT hits COMPARE.
        ip_d = {ti_d, sync_q[SYNC_STAGES-1], bus.sw_ip};
    end

    always_comb begin
        pend     = ip_q & bus.status_im;
        enable   = bus.status_ie & ~bus.status_exl & ~bus.status_erl;
        take     = (|pend) & enable;
        pend_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) begin
                pend_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_req_d  = 1'b0;
        irq_line_d = irq_line_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d    = REQ;
                    irq_req_d  = 1'b1;
                    irq_line_d = pend_idx;
                end
            end
            REQ: begin
                irq_req_d = 1'b1;
                if (bus.irq_ack) begin
                    state_d   = WAIT_EXL;
                    irq_req_d = 1'b0;
                end else if (!take) begin
                    state_d   = IDLE;
                    irq_req_d = 1'b0;
                end
            end
            WAIT_EXL: begin
                if (bus.status_exl || bus.status_erl) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            ti_q       <= 1'b0;
            sync_q     <= '0;
            ip_q       <= '0;
            irq_req_q  <= 1'b0;
            irq_line_q <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            ti_q       <= ti_d;
            sync_q     <= sync_d;
            ip_q       <= ip_d;
            irq_req_q  <= irq_req_d;
            irq_line_q <= irq_line_d;
        end
    end

    assign bus.count_out   = count_q;
    assign bus.compare_out = compare_q;
    assign bus.ip_out      = ip_q;
    assign bus.irq_req     = irq_req_q;
    assign bus.irq_line    = irq_line_q;
endmodule

// File: tb/tb_cop_irq_timer.sv
// Scenario bench for cop_irq_timer: expected values are queued as stimulus is
// applied and popped as each clock edge produces the DUT response.
module tb_cop_irq_timer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] exp_count_q[$];
    logic        exp_bit_q[$];
    logic        exp_req_q[$];
    logic [7:0]  exp_ip_q[$];

    cop_irq_if bus();

    cop_irq_timer #(.COUNT_DIV(2), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hw_irq     = '0;
        bus.sw_ip      = '0;
        bus.status_im  = '0;
        bus.status_ie  = 1'b0;
        bus.status_exl = 1'b0;
        bus.status_erl = 1'b0;
        bus.count_wr   = 1'b0;
        bus.compare_wr = 1'b0;
        bus.wr_data    = '0;
        bus.irq_ack    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.sw_ip   = 2'b11;
        bus.wr_data = 32'h1234_5678;
        bus.count_wr = 1'b1;
        tick();
        tick();
        checks++; if (bus.count_out !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=%h", bus.count_out, 32'd0); end
        checks++; if (bus.compare_out !== 32'd0) begin failures++; $display("FAIL reset_compare got=%h exp=%h", bus.compare_out, 32'd0); end
        checks++; if (bus.ip_out !== 8'h00) begin failures++; $display("FAIL reset_ip got=%h exp=%h", bus.ip_out, 8'h00); end
        checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.irq_req); end
        checks++; if (bus.irq_line !== 3'd0) begin failures++; $display("FAIL reset_line got=%0d exp=0", bus.irq_line); end
        idle_inputs();
    endtask

    task automatic test_count_match();
        logic [31:0] ec;
        logic        et;
        do_reset();
        bus.status_im  = 8'h80;
        bus.status_ie  = 1'b1;
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'd5;
        for (int k = 1; k <= 10; k++) begin
            exp_count_q.push_back(32'(k / 2));
            exp_bit_q.push_back(k == 10);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            bus.compare_wr = 1'b0;
            ec = exp_count_q.pop_front();
            et = exp_bit_q.pop_front();
            checks++; if (bus.count_out !== ec) begin failures++; $display("FAIL match_count edge=%0d got=%0d exp=%0d", k, bus.count_out, ec); end
            checks++; if (bus.ip_out[7] !== et) begin failures++; $display("FAIL match_ti edge=%0d got=%b exp=%b", k, bus.ip_out[7], et); end
            checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL match_req_early edge=%0d got=%b exp=0", k, bus.irq_req); end
        end
        tick();
        checks++; if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL match_req got=%b exp=1", bus.irq_req); end
        checks++; if (bus.irq_line !== 3'd7) begin failures++; $display("FAIL match_line got=%0d exp=7", bus.irq_line); end
        checks++; if (bus.compare_out !== 32'd5) begin failures++; $display("FAIL match_compare got=%0d exp=5", bus.compare_out); end
    endtask

    task automatic test_count_wrap();
        logic [31:0] ec;
        do_reset();
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'd5;
        tick();
        bus.compare_wr = 1'b0;
        bus.count_wr   = 1'b1;
        bus.wr_data    = 32'hFFFF_FFFE;
        exp_count_q.push_back(32'hFFFF_FFFE);
        exp_count_q.push_back(32'hFFFF_FFFE);
        exp_count_q.push_back(32'hFFFF_FFFF);
        exp_count_q.push_back(32'hFFFF_FFFF);
        exp_count_q.push_back(32'h0000_0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.count_wr = 1'b0;
            ec = exp_count_q.pop_front();
            checks++; if (bus.count_out !== ec) begin failures++; $display("FAIL wrap_count step=%0d got=%h exp=%h", k, bus.count_out, ec); end
            checks++; if (bus.ip_out[7] !== 1'b0) begin failures++; $display("FAIL wrap_ti step=%0d got=%b exp=0", k, bus.ip_out[7]); end
        end
        bus.count_wr = 1'b1;
        bus.wr_data  = 32'd5;
        exp_count_q.push_back(32'd5);
        exp_count_q.push_back(32'd5);
        exp_count_q.push_back(32'd6);
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.count_wr = 1'b0;
            ec = exp_count_q.pop_front();
            checks++; if (bus.count_out !== ec) begin failures++; $display("FAIL load_count step=%0d got=%0d exp=%0d", k, bus.count_out, ec); end
            checks++; if (bus.ip_out[7] !== 1'b0) begin failures++; $display("FAIL load_ti step=%0d got=%b exp=0", k, bus.ip_out[7]); end
        end
    endtask

    task automatic test_hw_sync();
        logic eb;
        do_reset();
        bus.status_ie = 1'b1;
        bus.status_im = 8'h00;
        bus.hw_irq    = 5'b00100;
        exp_bit_q.push_back(1'b0);
        exp_bit_q.push_back(1'b0);
        exp_bit_q.push_back(1'b1);
        exp_bit_q.push_back(1'b0);
        exp_bit_q.push_back(1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.hw_irq = '0;
            eb = exp_bit_q.pop_front();
            checks++; if (bus.ip_out[4] !== eb) begin failures++; $display("FAIL sync_ip4 edge=%0d got=%b exp=%b", k, bus.ip_out[4], eb); end
            checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL sync_masked_req edge=%0d got=%b exp=0", k, bus.irq_req); end
        end
        bus.sw_ip = 2'b01;
        exp_ip_q.push_back(8'h01);
        tick();
        checks++; if (bus.ip_out !== exp_ip_q[0]) begin failures++; $display("FAIL sw_ip got=%h exp=%h", bus.ip_out, exp_ip_q[0]); end
        void'(exp_ip_q.pop_front());
        tick();
        checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL sw_masked_req got=%b exp=0", bus.irq_req); end
    endtask

    task automatic test_priority_exl();
        logic [7:0] ei;
        logic       er;
        do_reset();
        bus.status_ie = 1'b1;
        bus.status_im = 8'hFF;
        bus.hw_irq    = 5'b10001;
        exp_ip_q.push_back(8'h00); exp_req_q.push_back(1'b0);
        exp_ip_q.push_back(8'h00); exp_req_q.push_back(1'b0);
        exp_ip_q.push_back(8'h44); exp_req_q.push_back(1'b0);
        exp_ip_q.push_back(8'h44); exp_req_q.push_back(1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            ei = exp_ip_q.pop_front();
            er = exp_req_q.pop_front();
            checks++; if (bus.ip_out !== ei) begin failures++; $display("FAIL prio_ip edge=%0d got=%h exp=%h", k, bus.ip_out, ei); end
            checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL prio_req edge=%0d got=%b exp=%b", k, bus.irq_req, er); end
        end
        checks++; if (bus.irq_line !== 3'd6) begin failures++; $display("FAIL prio_line got=%0d exp=6", bus.irq_line); end
        bus.irq_ack = 1'b1;
        exp_req_q.push_back(1'b0);
        tick();
        bus.irq_ack = 1'b0;
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL ack_req got=%b exp=%b", bus.irq_req, er); end
        exp_req_q.push_back(1'b0);
        tick();
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL wait_exl_hold got=%b exp=%b", bus.irq_req, er); end
        bus.status_exl = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_req_q.push_back(1'b0);
            tick();
            er = exp_req_q.pop_front();
            checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL exl_no_rereq step=%0d got=%b exp=%b", k, bus.irq_req, er); end
        end
        bus.status_exl = 1'b0;
        exp_req_q.push_back(1'b1);
        tick();
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL rereq got=%b exp=%b", bus.irq_req, er); end
        checks++; if (bus.irq_line !== 3'd6) begin failures++; $display("FAIL rereq_line got=%0d exp=6", bus.irq_line); end
    endtask

    task automatic test_withdraw();
        logic er;
        do_reset();
        bus.status_ie = 1'b1;
        bus.status_im = 8'h01;
        bus.sw_ip     = 2'b01;
        tick();
        exp_req_q.push_back(1'b1);
        tick();
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL wd_req got=%b exp=%b", bus.irq_req, er); end
        checks++; if (bus.irq_line !== 3'd0) begin failures++; $display("FAIL wd_line got=%0d exp=0", bus.irq_line); end
        bus.status_ie = 1'b0;
        exp_req_q.push_back(1'b0);
        tick();
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL wd_withdraw got=%b exp=%b", bus.irq_req, er); end
        bus.status_ie = 1'b1;
        exp_req_q.push_back(1'b1);
        tick();
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL wd_rereq got=%b exp=%b", bus.irq_req, er); end
        bus.status_ie = 1'b0;
        bus.irq_ack   = 1'b1;
        exp_req_q.push_back(1'b0);
        tick();
        bus.irq_ack   = 1'b0;
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL wd_ack_race got=%b exp=%b", bus.irq_req, er); end
        // Re-enabling must not re-request: the ack should have parked the FSM in WAIT_EXL.
        bus.status_ie = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_req_q.push_back(1'b0);
            tick();
            er = exp_req_q.pop_front();
            checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL wd_wait_exl step=%0d got=%b exp=%b", k, bus.irq_req, er); end
        end
        bus.status_erl = 1'b1;
        tick();
        bus.status_erl = 1'b0;
        exp_req_q.push_back(1'b1);
        tick();
        er = exp_req_q.pop_front();
        checks++; if (bus.irq_req !== er) begin failures++; $display("FAIL wd_after_erl got=%b exp=%b", bus.irq_req, er); end
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'd3;
        tick();
        bus.compare_wr = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'd3;
        exp_count_q.push_back(32'd3);
        tick();
        bus.compare_wr = 1'b0;
        checks++; if (bus.count_out !== exp_count_q[0]) begin failures++; $display("FAIL clr_count got=%0d exp=%0d", bus.count_out, exp_count_q[0]); end
        void'(exp_count_q.pop_front());
        checks++; if (bus.ip_out[7] !== 1'b0) begin failures++; $display("FAIL clr_beats_match got=%b exp=0", bus.ip_out[7]); end
        tick();
        tick();
        checks++; if (bus.ip_out[7] !== 1'b0) begin failures++; $display("FAIL clr_ti_later got=%b exp=0", bus.ip_out[7]); end
        checks++; if (bus.count_out !== 32'd4) begin failures++; $display("FAIL clr_count_later got=%0d exp=4", bus.count_out); end
        bus.sw_ip     = 2'b10;
        bus.status_im = 8'h02;
        bus.status_ie = 1'b1;
        tick();
        tick();
        checks++; if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req got=%b exp=1", bus.irq_req); end
        checks++; if (bus.irq_line !== 3'd1) begin failures++; $display("FAIL rst_pre_line got=%0d exp=1", bus.irq_line); end
        rst = 1'b1;
        tick();
        checks++; if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.irq_req); end
        checks++; if (bus.count_out !== 32'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count_out); end
        checks++; if (bus.ip_out !== 8'h00) begin failures++; $display("FAIL rst_ip got=%h exp=00", bus.ip_out); end
        checks++; if (bus.compare_out !== 32'd0) begin failures++; $display("FAIL rst_compare got=%0d exp=0", bus.compare_out); end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_count_match();
        test_count_wrap();
        test_hw_sync();
        test_priority_exl();
        test_withdraw();
        test_clear_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
